// File: rtl/scsi_reg_cycle_pkg.sv
// Shared types and constants for the WD33C93 register-access sequencer.
package scsi_reg_cycle_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [2:0] WD_WIN_DEF  = 3'b100;
    localparam logic [6:0] WD_SASR_OFS = 7'h40;
    localparam logic [6:0] WD_DATA_OFS = 7'h48;

    localparam int unsigned DEF_SETUP_CYC    = 1;
    localparam int unsigned DEF_STROBE_CYC   = 4;
    localparam int unsigned DEF_HOLD_CYC     = 1;
    localparam int unsigned DEF_RECOVERY_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_TERM    = 3'd4,
        ST_RECOVER = 3'd5
    } state_e;

    // Counter load value for a phase lasting cyc clocks (counter expires at zero).
    function automatic logic [CNT_W-1:0] cyc_load(input int unsigned cyc);
        return (cyc == 0) ? '0 : CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/scsi_reg_cycle_if.sv
// Host/chip-side signal bundle of the WD33C93 register sequencer.
interface scsi_reg_cycle_if;
    import scsi_reg_cycle_pkg::*;

    logic              AS_;
    logic              DMAC_;
    logic              R_W;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] SCSI_DIN;
    logic              WDREGREQ;
    logic              WD_DSK_;
    logic              SCSI_CS_;
    logic              SCSI_RE_;
    logic              SCSI_WE_;
    logic              SCSI_A0;
    logic [DATA_W-1:0] RDATA;

    modport master (
        output AS_, DMAC_, R_W, ADDR, SCSI_DIN,
        input  WDREGREQ, WD_DSK_, SCSI_CS_, SCSI_RE_, SCSI_WE_, SCSI_A0, RDATA
    );

    modport slave (
        input  AS_, DMAC_, R_W, ADDR, SCSI_DIN,
        output WDREGREQ, WD_DSK_, SCSI_CS_, SCSI_RE_, SCSI_WE_, SCSI_A0, RDATA
    );

endinterface

// File: rtl/scsi_reg_timer.sv
// Loadable down-counter shared by all timed phases; zero_c flags expiry.
module scsi_reg_timer
    import scsi_reg_cycle_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/scsi_reg_cycle.sv
// WD33C93 register-access sequencer: decode, CS_/RE_/WE_ timing, read capture,
// own cycle termination and inter-access recovery.
module scsi_reg_cycle
    import scsi_reg_cycle_pkg::*;
#(
    parameter logic [2:0]  WD_WIN       = WD_WIN_DEF,
    parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC   = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
    parameter int unsigned RECOVERY_CYC = DEF_RECOVERY_CYC
) (
    input  logic             CLK,
    input  logic             RESET_,
    scsi_reg_cycle_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETUP_LD   = cyc_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD  = cyc_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD    = cyc_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] RECOVER_LD = cyc_load(RECOVERY_CYC);

    state_e            state_q, state_d;
    logic              wdregreq_q, wdregreq_d;
    logic              dsk_n_q, dsk_n_d;
    logic              cs_n_q, cs_n_d;
    logic              re_n_q, re_n_d;
    logic              we_n_q, we_n_d;
    logic              a0_q, a0_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              hit_c;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero_c;
    logic              to_recover;
    logic              unused_addr_c;

    // ADDR holds host address bits [6:2]; [4:2] is the window, [1] is A3 -> A0.
    assign hit_c         = ~bus.AS_ & ~bus.DMAC_ & (bus.ADDR[4:2] == WD_WIN);
    assign unused_addr_c = bus.ADDR[0];

    scsi_reg_timer u_timer (
        .CLK      (CLK),
        .RESET_   (RESET_),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            state_q    <= ST_IDLE;
            wdregreq_q <= 1'b0;
            dsk_n_q    <= 1'b1;
            cs_n_q     <= 1'b1;
            re_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            a0_q       <= 1'b0;
            rw_q       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wdregreq_q <= wdregreq_d;
            dsk_n_q    <= dsk_n_d;
            cs_n_q     <= cs_n_d;
            re_n_q     <= re_n_d;
            we_n_q     <= we_n_d;
            a0_q       <= a0_d;
            rw_q       <= rw_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wdregreq_d = wdregreq_q;
        dsk_n_d    = dsk_n_q;
        cs_n_d     = cs_n_q;
        re_n_d     = re_n_q;
        we_n_d     = we_n_q;
        a0_d       = a0_q;
        rw_d       = rw_q;
        rdata_d    = rdata_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        to_recover = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                wdregreq_d = hit_c;
                if (hit_c) begin
                    state_d  = ST_SETUP;
                    cs_n_d   = 1'b0;
                    a0_d     = bus.ADDR[1];
                    rw_d     = bus.R_W;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                // Host abandoning the cycle overrides any phase completion.
                if (bus.AS_) begin
                    cs_n_d     = 1'b1;
                    re_n_d     = 1'b1;
                    we_n_d     = 1'b1;
                    wdregreq_d = 1'b0;
                    to_recover = 1'b1;
                end else if (tmr_zero_c) begin
                    if (state_q == ST_SETUP) begin
                        state_d  = ST_STROBE;
                        re_n_d   = ~rw_q;
                        we_n_d   = rw_q;
                        tmr_load = 1'b1;
                        tmr_val  = STROBE_LD;
                    end else if (state_q == ST_STROBE && HOLD_CYC != 0) begin
                        state_d  = ST_HOLD;
                        re_n_d   = 1'b1;
                        we_n_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                        if (rw_q) begin
                            rdata_d = bus.SCSI_DIN;
                        end
                    end else begin
                        state_d = ST_TERM;
                        re_n_d  = 1'b1;
                        we_n_d  = 1'b1;
                        cs_n_d  = 1'b1;
                        dsk_n_d = 1'b0;
                        if (state_q == ST_STROBE && rw_q) begin
                            rdata_d = bus.SCSI_DIN;
                        end
                    end
                end
            end
            ST_TERM: begin
                if (bus.AS_) begin
                    dsk_n_d    = 1'b1;
                    wdregreq_d = 1'b0;
                    to_recover = 1'b1;
                end
            end
            ST_RECOVER: begin
                // Claim a new hit early so the terminator never responds to it.
                wdregreq_d = hit_c;
                if (tmr_zero_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_recover) begin
            if (RECOVERY_CYC == 0) begin
                state_d = ST_IDLE;
            end else begin
                state_d  = ST_RECOVER;
                tmr_load = 1'b1;
                tmr_val  = RECOVER_LD;
            end
        end
    end

    assign bus.WDREGREQ = wdregreq_q;
    assign bus.WD_DSK_  = dsk_n_q;
    assign bus.SCSI_CS_ = cs_n_q;
    assign bus.SCSI_RE_ = re_n_q;
    assign bus.SCSI_WE_ = we_n_q;
    assign bus.SCSI_A0  = a0_q;
    assign bus.RDATA    = rdata_q;

endmodule

// File: tb/tb_scsi_reg_cycle.sv
// Bench for scsi_reg_cycle: directed and random host accesses checked every clock
// against a timeline model of the WD33C93 register-cycle rules.
module tb_scsi_reg_cycle;
    import scsi_reg_cycle_pkg::*;

    localparam int S  = int'(DEF_SETUP_CYC);
    localparam int ST = int'(DEF_STROBE_CYC);
    localparam int H  = int'(DEF_HOLD_CYC);
    localparam int R  = int'(DEF_RECOVERY_CYC);
    localparam int T  = S + ST + H;

    logic clk;
    logic rst_n;

    scsi_reg_cycle_if bus ();

    scsi_reg_cycle #(
        .WD_WIN       (WD_WIN_DEF),
        .SETUP_CYC    (DEF_SETUP_CYC),
        .STROBE_CYC   (DEF_STROBE_CYC),
        .HOLD_CYC     (DEF_HOLD_CYC),
        .RECOVERY_CYC (DEF_RECOVERY_CYC)
    ) dut (
        .CLK    (clk),
        .RESET_ (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ecnt  = 0;
    int ready = 0;

    // Current transaction as seen by the model (absolute edge numbers).
    bit         tx_hit = 1'b0;
    int         tx_a   = 0;
    int         tx_es  = 0;
    int         tx_b   = 0;
    bit         tx_rw  = 1'b0;
    bit         tx_a0  = 1'b0;
    logic [7:0] tx_din = 8'h00;
    logic [7:0] rdata_exp = 8'h00;
    logic       a0_exp    = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, ecnt, obs, exp);
        end
    endtask

    // Advance one clock, then compare every output with the timeline model.
    task automatic step();
        int   n;
        int   len;
        logic ex_cs, ex_re, ex_we, ex_dsk, ex_req;
        @(posedge clk);
        ecnt++;
        #1;
        if (!rst_n) begin
            tx_hit    = 1'b0;
            rdata_exp = 8'h00;
            a0_exp    = 1'b0;
            ready     = ecnt + 1;
        end
        ex_cs = 1'b1; ex_re = 1'b1; ex_we = 1'b1; ex_dsk = 1'b1; ex_req = 1'b0;
        if (tx_hit) begin
            n   = ecnt - tx_es + 1;
            len = tx_b - tx_es;
            if (ecnt == tx_es) a0_exp = tx_a0;
            if (n >= 1 && n <= len && n <= T) ex_cs = 1'b0;
            if (n >= S + 1 && n <= len && n <= S + ST) begin
                if (tx_rw) ex_re = 1'b0;
                else       ex_we = 1'b0;
            end
            if (n >= T + 1 && n <= len) ex_dsk = 1'b0;
            if (tx_rw && n == S + ST + 1 && len >= S + ST + 1) rdata_exp = tx_din;
            if (ecnt >= tx_a && ecnt < tx_b) ex_req = 1'b1;
        end
        chk("WDREGREQ", 8'(bus.WDREGREQ), 8'(ex_req));
        chk("WD_DSK_",  8'(bus.WD_DSK_),  8'(ex_dsk));
        chk("SCSI_CS_", 8'(bus.SCSI_CS_), 8'(ex_cs));
        chk("SCSI_RE_", 8'(bus.SCSI_RE_), 8'(ex_re));
        chk("SCSI_WE_", 8'(bus.SCSI_WE_), 8'(ex_we));
        chk("SCSI_A0",  8'(bus.SCSI_A0),  8'(a0_exp));
        chk("RDATA",    bus.RDATA,        rdata_exp);
    endtask

    task automatic idle(input int g);
        repeat (g) step();
    endtask

    // Assert AS_ for an access; len = clocks AS_ stays low, counted from the
    // clock the block accepts the hit (or from assertion for a non-hit).
    task automatic launch(input bit dmac_n, input bit rw, input logic [4:0] addr,
                          input logic [7:0] din, input int len);
        bus.AS_      = 1'b0;
        bus.DMAC_    = dmac_n;
        bus.R_W      = rw;
        bus.ADDR     = addr;
        bus.SCSI_DIN = din;
        tx_a   = ecnt + 1;
        tx_hit = !dmac_n && (addr[4:2] == WD_WIN_DEF);
        if (tx_hit) begin
            tx_es  = (tx_a > ready) ? tx_a : ready;
            tx_b   = tx_es + len;
            ready  = tx_b + R + 1;
            tx_rw  = rw;
            tx_a0  = addr[1];
            tx_din = din;
        end else begin
            tx_b = tx_a + len;
        end
    endtask

    task automatic finish_tx();
        while (ecnt < tx_b - 1) step();
        bus.AS_ = 1'b1;
    endtask

    initial begin
        logic [4:0] addr;
        bit         dmac_n;
        int         kind;

        rst_n        = 1'b0;
        bus.AS_      = 1'b1;
        bus.DMAC_    = 1'b1;
        bus.R_W      = 1'b1;
        bus.ADDR     = 5'h00;
        bus.SCSI_DIN = 8'h00;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Read of the data register (0x48).
        launch(1'b0, 1'b1, 5'h12, 8'hA5, T + 2); finish_tx(); idle(2);
        // Write to SASR (0x40); RDATA must keep A5.
        launch(1'b0, 1'b0, 5'h10, 8'h3C, T + 1); finish_tx(); idle(1);
        // Back-to-back reads, AS_ high for a single clock.
        launch(1'b0, 1'b1, 5'h12, 8'h5A, T + 1); finish_tx(); idle(1);
        launch(1'b0, 1'b1, 5'h10, 8'hC3, T + 1); finish_tx(); idle(3);
        // AS_ rises during the second strobe clock.
        launch(1'b0, 1'b1, 5'h12, 8'hFF, S + 2); finish_tx(); idle(3);
        // Non-hits: offset 0x0C, offset 0x20, WD window without DMAC_.
        launch(1'b0, 1'b1, 5'h03, 8'h11, 8); finish_tx(); idle(1);
        launch(1'b0, 1'b0, 5'h08, 8'h22, 8); finish_tx(); idle(1);
        launch(1'b1, 1'b1, 5'h12, 8'h33, 8); finish_tx(); idle(2);

        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 8) begin
                addr = {WD_WIN_DEF, 2'($urandom_range(0, 3))};
                launch(1'b0, 1'($urandom_range(0, 1)), addr, 8'($urandom),
                       (kind < 6) ? T + 1 + int'($urandom_range(0, 3))
                                  : int'($urandom_range(1, T)));
            end else begin
                addr   = 5'($urandom_range(0, 31));
                dmac_n = (addr[4:2] == WD_WIN_DEF) ? 1'b1 : 1'($urandom_range(0, 1));
                launch(dmac_n, 1'($urandom_range(0, 1)), addr, 8'($urandom),
                       int'($urandom_range(2, 9)));
            end
            finish_tx();
            idle(($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(1, 4)));
        end

        // Reset while the read strobe is active.
        idle(4);
        launch(1'b0, 1'b1, 5'h12, 8'h77, T + 2);
        while (ecnt < tx_es + S + 1) step();
        rst_n   = 1'b0;
        bus.AS_ = 1'b1;
        step();
        rst_n = 1'b1;
        idle(3);
        launch(1'b0, 1'b1, 5'h10, 8'h9E, T + 1); finish_tx(); idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
